memory_responder: RTL and testbench

Memory-side responder for the RISC240 memory bus: it answers the processor's `re_L`/`we_L` strobes on the shared tristate `dataBus`, backing them with a word-organised RAM plus a small memory-mapped I/O block (switches, LEDs, cycle counter, status). Read data is returned on the cycle after the read strobe, which is the timing the processor's synthesis-mode MDR path (`prop_re_L`) expects. The block sits at the top level beside the processor and is the only agent other than the processor that drives `dataBus`.

---
 rtl/memory_responder.sv | 155 +++++++++++++++
 tb/tb_memory_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
//==============================================================================
//  Module      : memory_responder
//  Description : Memory-side responder for the RISC240 memory bus. Answers
//                re_L/we_L strobes on the shared tristate dataBus from a
//                word-organised RAM and a small memory-mapped I/O block
//                (switches, LEDs, free-running cycle counter, status).
//                Read data is returned on the cycle after the read strobe.
//  Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module memory_responder #(
    parameter int    AW        = 12,
    parameter string INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic [15:0] memAddr,
    input  logic        re_L,
    input  logic        we_L,
    inout  wire  [15:0] dataBus,
    input  logic [15:0] switches,
    output logic [15:0] ledOut,
    output logic        busErr
);

    // First byte address past the end of RAM.
    localparam int unsigned c_RAM_LIMIT = 2 ** (AW + 1);
    localparam int unsigned c_RAM_WORDS = 2 ** AW;

    // IO register indices, taken from memAddr[3:1] inside the IO window.
    localparam logic [2:0] c_IO_SW   = 3'd0;
    localparam logic [2:0] c_IO_LED  = 3'd1;
    localparam logic [2:0] c_IO_CNT  = 3'd2;
    localparam logic [2:0] c_IO_STAT = 3'd3;

    logic [15:0] r_mem [0:c_RAM_WORDS-1];
    logic [15:0] r_led;
    logic [15:0] r_cnt;
    logic [1:0]  r_stat;
    logic [15:0] r_rd_data;
    logic        r_drive_en;

    logic          w_is_io;
    logic          w_is_ram;
    logic          w_is_unmapped;
    logic [AW-1:0] w_ram_idx;
    logic [2:0]    w_io_idx;
    logic          w_wr;
    logic          w_rd;
    logic          w_conflict;
    logic          w_wr_led;
    logic          w_wr_cnt;
    logic          w_wr_stat;
    logic [15:0]   w_rd_val;
    logic [1:0]    w_stat_set;
    logic [1:0]    w_stat_clr;
    logic          w_unused;

    // Accesses are word-only, so the byte-select bit is deliberately dropped.
    assign w_unused = memAddr[0];

    // The IO window is checked first so it wins if a large RAM would overlap it.
    assign w_is_io       = (memAddr >= 16'hFFF0);
    assign w_is_ram      = !w_is_io && ({16'd0, memAddr} < c_RAM_LIMIT);
    assign w_is_unmapped = !w_is_io && !w_is_ram;
    assign w_ram_idx     = memAddr[AW:1];
    assign w_io_idx      = memAddr[3:1];

    // A write strobe always wins; a read is only honoured with we_L high.
    assign w_wr       = !we_L;
    assign w_rd       = !re_L && we_L;
    assign w_conflict = !re_L && !we_L;

    assign w_wr_led  = w_wr && w_is_io && (w_io_idx == c_IO_LED);
    assign w_wr_cnt  = w_wr && w_is_io && (w_io_idx == c_IO_CNT);
    assign w_wr_stat = w_wr && w_is_io && (w_io_idx == c_IO_STAT);

    assign w_stat_set = {w_is_unmapped && (w_wr || w_rd), w_conflict};
    assign w_stat_clr = w_wr_stat ? dataBus[1:0] : 2'b00;

    // Read-data mux: IO registers, RAM word, or zero for unmapped/reserved.
    always_comb begin
        w_rd_val = 16'h0000;
        if (w_is_io) begin
            case (w_io_idx)
                c_IO_SW:   w_rd_val = switches;
                c_IO_LED:  w_rd_val = r_led;
                c_IO_CNT:  w_rd_val = r_cnt;
                c_IO_STAT: w_rd_val = {14'd0, r_stat};
                default:   w_rd_val = 16'h0000;
            endcase
        end else if (w_is_ram) begin
            w_rd_val = r_mem[w_ram_idx];
        end
    end

    // RAM write port; strobes seen during reset are ignored.
    always_ff @(posedge clock) begin
        if (reset_L && w_wr && w_is_ram) begin
            r_mem[w_ram_idx] <= dataBus;
        end
    end

    // Read capture: data is held for the cycle after the strobe.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_rd_data  <= 16'h0000;
            r_drive_en <= 1'b0;
        end else begin
            r_drive_en <= w_rd;
            if (w_rd) begin
                r_rd_data <= w_rd_val;
            end
        end
    end

    // LED register.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_led <= 16'h0000;
        end else if (w_wr_led) begin
            r_led <= dataBus;
        end
    end

    // Free-running cycle counter; a write clears it and overrides the increment.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_cnt <= 16'h0000;
        end else if (w_wr_cnt) begin
            r_cnt <= 16'h0000;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Sticky status bits with write-one-to-clear; a same-edge set wins.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_stat <= 2'b00;
        end else begin
            r_stat <= (r_stat & ~w_stat_clr) | w_stat_set;
        end
    end

    // Drive the bus only while the processor is not writing.
    assign dataBus = (r_drive_en && we_L) ? r_rd_data : 16'hzzzz;
    assign ledOut  = r_led;
    assign busErr  = r_stat[0];

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
//==============================================================================
//  Module      : tb_memory_responder
//  Description : Self-checking bench for memory_responder: directed vector
//                table, counter clear/priority sequence, and randomized
//                traffic against a behavioural bus/memory model.
//  Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_memory_responder;

    logic        clock = 1'b0;
    logic        reset_L = 1'b0;
    logic [15:0] memAddr = 16'h0000;
    logic        re_L = 1'b1;
    logic        we_L = 1'b1;
    logic [15:0] switches = 16'h0000;
    logic [15:0] tb_wd = 16'h0000;
    wire  [15:0] dataBus;
    wire  [15:0] ledOut;
    wire         busErr;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] bus_seen;

    // Processor side of the bus: drives write data while we_L is low.
    assign dataBus = (!we_L) ? tb_wd : 16'hzzzz;

    memory_responder #(.AW(12), .INIT_FILE("")) dut (
        .clock    (clock),
        .reset_L  (reset_L),
        .memAddr  (memAddr),
        .re_L     (re_L),
        .we_L     (we_L),
        .dataBus  (dataBus),
        .switches (switches),
        .ledOut   (ledOut),
        .busErr   (busErr)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    bit [15:0] m_mem [0:4095];
    bit [15:0] m_led;
    bit [15:0] m_cnt;
    bit [15:0] m_rd;
    bit [1:0]  m_stat;
    bit        m_drive;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_rel(input string name, input logic [15:0] act);
        n_cmp++;
        if (!($isunknown(act) || act == 16'h0000)) begin
            n_err++;
            $display("FAIL %s: got %h, expected bus released", name, act);
        end
    endtask

    // One rising edge of the bus as seen from the memory map rules.
    task automatic model_edge(input bit rst, input bit re, input bit we,
                              input bit [15:0] addr, input bit [15:0] wd, input bit [15:0] sw);
        bit io, ram, rd, wr;
        int reg_n;
        bit [15:0] val, nxt_cnt;
        bit [1:0] set, clr;
        if (!rst) begin
            m_led = 0; m_cnt = 0; m_stat = 0; m_drive = 0; m_rd = 0;
            return;
        end
        io    = (addr >= 16'hFFF0);
        ram   = !io && (addr < 16'h2000);
        reg_n = io ? (int'(addr) - 'hFFF0) / 2 : 0;
        rd    = !re && we;
        wr    = !we;
        set   = 0;
        clr   = 0;
        nxt_cnt = m_cnt + 1;
        if (rd) begin
            val = 0;
            if (ram) val = m_mem[addr / 2];
            else if (io) begin
                if (reg_n == 0) val = sw;
                else if (reg_n == 1) val = m_led;
                else if (reg_n == 2) val = m_cnt;
                else if (reg_n == 3) val = {14'd0, m_stat};
            end else set[1] = 1;
            m_rd = val;
        end
        m_drive = rd;
        if (wr) begin
            if (ram) m_mem[addr / 2] = wd;
            else if (io) begin
                if (reg_n == 1) m_led = wd;
                else if (reg_n == 2) nxt_cnt = 0;
                else if (reg_n == 3) clr = wd[1:0];
            end else set[1] = 1;
        end
        if (!re && !we) set[0] = 1;
        m_stat = (m_stat & ~clr) | set;
        m_cnt  = nxt_cnt;
    endtask

    // Apply one cycle of inputs: observe the bus before the edge, then the
    // registered outputs just after it.
    task automatic apply(input bit rst, input bit re, input bit we, input bit [15:0] addr,
                         input bit [15:0] wd, input bit [15:0] sw, input bit chk);
        reset_L = rst; re_L = re; we_L = we; memAddr = addr; tb_wd = wd; switches = sw;
        #1;
        bus_seen = dataBus;
        if (chk) begin
            if (!we) check16("rnd_bus_wr", bus_seen, wd);
            else if (m_drive) check16("rnd_bus_rd", bus_seen, m_rd);
            else check_rel("rnd_bus_idle", bus_seen);
        end
        @(posedge clock);
        model_edge(rst, re, we, addr, wd, sw);
        #1;
        if (chk) begin
            check16("rnd_led", ledOut, m_led);
            check16("rnd_busErr", {15'd0, busErr}, {15'd0, m_stat[0]});
        end
    endtask

    typedef struct {
        bit        rst, re, we;
        bit [15:0] addr, wd, sw;
        int        bmode;   // 0 released, 1 value, 2 don't care
        bit [15:0] ebus, eled;
        bit        eerr;
    } vec_t;

    function automatic vec_t mk(bit rst, bit re, bit we, bit [15:0] addr, bit [15:0] wd,
                                bit [15:0] sw, int bmode, bit [15:0] ebus, bit [15:0] eled, bit eerr);
        vec_t v;
        v.rst = rst; v.re = re; v.we = we; v.addr = addr; v.wd = wd; v.sw = sw;
        v.bmode = bmode; v.ebus = ebus; v.eled = eled; v.eerr = eerr;
        return v;
    endfunction

    localparam int NV = 30;
    vec_t tbl [NV];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        //            rst re we addr      wd       sw       bm ebus     eled     err
        tbl[0]  = mk(0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 2, 16'h0000, 16'h0000, 0);
        tbl[1]  = mk(0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[2]  = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[3]  = mk(1, 1, 0, 16'h0010, 16'hBEEF, 16'h0000, 1, 16'hBEEF, 16'h0000, 0);
        tbl[4]  = mk(1, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[5]  = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h0000, 0);
        tbl[6]  = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[7]  = mk(1, 1, 0, 16'hFFF2, 16'h00A5, 16'h0000, 1, 16'h00A5, 16'h00A5, 0);
        tbl[8]  = mk(1, 0, 1, 16'hFFF0, 16'h0000, 16'h1234, 0, 16'h0000, 16'h00A5, 0);
        tbl[9]  = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 16'h1234, 16'h00A5, 0);
        tbl[10] = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h00A5, 0);
        tbl[11] = mk(1, 0, 0, 16'h0020, 16'h5555, 16'h0000, 1, 16'h5555, 16'h00A5, 1);
        tbl[12] = mk(1, 0, 1, 16'h0020, 16'h0000, 16'h0000, 0, 16'h0000, 16'h00A5, 1);
        tbl[13] = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 16'h5555, 16'h00A5, 1);
        tbl[14] = mk(1, 1, 0, 16'hFFF6, 16'h0001, 16'h0000, 1, 16'h0001, 16'h00A5, 0);
        tbl[15] = mk(1, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000, 16'h00A5, 0);
        tbl[16] = mk(1, 1, 0, 16'hFFF2, 16'h0F0F, 16'h0000, 1, 16'h0F0F, 16'h0F0F, 0);
        tbl[17] = mk(1, 0, 1, 16'h4000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0F0F, 0);
        tbl[18] = mk(1, 0, 1, 16'hFFF6, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0F0F, 0);
        tbl[19] = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0002, 16'h0F0F, 0);
        tbl[20] = mk(1, 1, 0, 16'hFFF6, 16'h0002, 16'h0000, 1, 16'h0002, 16'h0F0F, 0);
        tbl[21] = mk(1, 0, 1, 16'hFFF6, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0F0F, 0);
        tbl[22] = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0F0F, 0);
        tbl[23] = mk(1, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0F0F, 0);
        tbl[24] = mk(0, 0, 1, 16'h0020, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h0000, 0);
        tbl[25] = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[26] = mk(0, 1, 0, 16'h0010, 16'h1111, 16'h0000, 1, 16'h1111, 16'h0000, 0);
        tbl[27] = mk(1, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[28] = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h0000, 0);
        tbl[29] = mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].rst, tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].sw, 1'b0);
            if (tbl[i].bmode == 1) check16($sformatf("vec%0d_bus", i), bus_seen, tbl[i].ebus);
            else if (tbl[i].bmode == 0) check_rel($sformatf("vec%0d_bus", i), bus_seen);
            check16($sformatf("vec%0d_led", i), ledOut, tbl[i].eled);
            check16($sformatf("vec%0d_busErr", i), {15'd0, busErr}, {15'd0, tbl[i].eerr});
        end

        // Counter: clear, run up to the top, then clear exactly at 0xFFFF
        apply(1, 1, 0, 16'hFFF4, 16'h1234, 16'h0000, 1'b1);
        guard = 0;
        while (m_cnt != 16'hFFFD && guard < 70000) begin
            apply(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
            guard++;
        end
        n_cmp++;
        if (m_cnt != 16'hFFFD) begin
            n_err++;
            $display("FAIL cnt_run_guard: got %h, expected fffd", m_cnt);
        end
        apply(1, 0, 1, 16'hFFF4, 16'h0000, 16'h0000, 1'b1);
        apply(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        check16("cnt_before_clear", bus_seen, 16'hFFFD);
        apply(1, 1, 0, 16'hFFF4, 16'hFFFF, 16'h0000, 1'b1);
        apply(1, 0, 1, 16'hFFF4, 16'h0000, 16'h0000, 1'b1);
        apply(1, 0, 1, 16'hFFF4, 16'h0000, 16'h0000, 1'b1);
        check16("cnt_after_clear", bus_seen, 16'h0000);
        apply(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        check16("cnt_next", bus_seen, 16'h0001);

        // Seed a RAM window so random reads have known contents
        for (int w = 0; w < 32; w++) begin
            apply(1, 1, 0, 16'(w * 2), 16'($urandom), 16'h0000, 1'b1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            bit rst, re, we;
            bit [15:0] addr;
            int cls;
            rst = ($urandom_range(0, 39) != 0);
            re  = $urandom_range(0, 2) == 0 ? 1'b1 : 1'b0;
            we  = $urandom_range(0, 2) != 0;
            cls = $urandom_range(0, 2);
            if (cls == 0) addr = 16'($urandom_range(0, 63));
            else if (cls == 1) addr = 16'hFFF0 | 16'($urandom_range(0, 15));
            else addr = 16'($urandom_range(16'h2000, 16'hFFEF));
            apply(rst, re, we, addr, 16'($urandom), 16'($urandom), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
